// File: rtl/sun_tracker_fsm_pkg.sv
// Shared encodings for the sun tracker: FSM states and the direction-enable pair
// that feeds the servo driver buttons (bit 0 -> BTN_0, bit 1 -> BTN_1).
package sun_tracker_fsm_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMove0 = 2'd1,
    StMove1 = 2'd2,
    StHold  = 2'd3
  } state_e;

  typedef logic [1:0] dir_t;

  localparam dir_t DirNone = 2'b00;
  localparam dir_t DirCw   = 2'b01;  // toward sensor A, position increments
  localparam dir_t DirCcw  = 2'b10;  // toward sensor B, position decrements

  localparam int unsigned PosW = 8;

  function automatic dir_t state_dir(input state_e st);
    dir_t dir;
    case (st)
      StMove0: dir = DirCw;
      StMove1: dir = DirCcw;
      default: dir = DirNone;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/sun_tracker_fsm_tick_prescaler.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle as TICK.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    TICK  = (cnt_q == CntLast);
    cnt_d = TICK ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sun_tracker_fsm.sv
// Per-axis sun-tracking decision stage: hysteretic LDR comparison driving the servo direction
// enables, with a tick-based position estimate, soft end-stops, move timeout and post-move hold.
module sun_tracker_fsm
  import sun_tracker_fsm_pkg::*;
#(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned THRESH     = 64,
  parameter int unsigned HYST       = 16,
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned POS_MAX    = 180,
  parameter int unsigned POS_INIT   = 90,
  parameter int unsigned MOVE_MAX   = 200,
  parameter int unsigned HOLD_TICKS = 50
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SAMPLE_VALID,
  input  logic [DATA_W-1:0] LDR_A,
  input  logic [DATA_W-1:0] LDR_B,
  output logic              DIR_0,
  output logic              DIR_1,
  output logic [PosW-1:0]   POS,
  output logic              AT_LIMIT,
  output logic              TIMEOUT
);

  localparam int unsigned CntMax = (MOVE_MAX > HOLD_TICKS) ? MOVE_MAX : HOLD_TICKS;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic signed [DATA_W:0] ThrS  = (DATA_W + 1)'(THRESH);
  localparam logic signed [DATA_W:0] HystS = (DATA_W + 1)'(HYST);
  localparam logic [PosW-1:0] PosMax  = PosW'(POS_MAX);
  localparam logic [PosW-1:0] PosInit = PosW'(POS_INIT);
  localparam logic [CntW-1:0] MoveMax  = CntW'(MOVE_MAX);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_TICKS - 1);

  logic                     tick;
  logic signed [DATA_W:0]   err;
  state_e                   state_q, state_d;
  logic [PosW-1:0]          pos_q, pos_d;
  logic [CntW-1:0]          cnt_q, cnt_d, cnt_step;
  dir_t                     dir_q, dir_d;
  logic                     timeout_q, timeout_d;
  logic                     at_limit_q, at_limit_d;
  logic                     end_stop, time_up, stop_req;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (tick)
  );

  assign err = $signed({1'b0, LDR_A}) - $signed({1'b0, LDR_B});

  // Position/count stepping; the end-stop test uses the post-tick position so a tick
  // that lands on the limit ends the move in that same cycle.
  always_comb begin
    pos_d    = pos_q;
    cnt_step = cnt_q;
    end_stop = 1'b0;
    time_up  = 1'b0;
    stop_req = 1'b0;
    unique case (state_q)
      StMove0: begin
        if (tick) begin
          pos_d    = (pos_q < PosMax) ? pos_q + 8'd1 : pos_q;
          cnt_step = cnt_q + 1'b1;
        end
        end_stop = (pos_d == PosMax);
        time_up  = (cnt_step >= MoveMax);
        stop_req = SAMPLE_VALID && (err <= HystS);
      end
      StMove1: begin
        if (tick) begin
          pos_d    = (pos_q != '0) ? pos_q - 8'd1 : pos_q;
          cnt_step = cnt_q + 1'b1;
        end
        end_stop = (pos_d == '0);
        time_up  = (cnt_step >= MoveMax);
        stop_req = SAMPLE_VALID && (err >= -HystS);
      end
      StHold: begin
        if (tick) cnt_step = cnt_q + 1'b1;
      end
      default: cnt_step = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (SAMPLE_VALID) begin
          if (err > ThrS && pos_q < PosMax) begin
            state_d = StMove0;
          end else if (err < -ThrS && pos_q != '0) begin
            state_d = StMove1;
          end
        end
      end
      StMove0, StMove1: begin
        if (end_stop || time_up || stop_req) state_d = StHold;
      end
      StHold: begin
        if (tick && cnt_q == HoldLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // TIMEOUT only when the timeout is the winning exit cause.
  always_comb begin
    dir_d      = state_dir(state_d);
    timeout_d  = (state_q == StMove0 || state_q == StMove1) && time_up && !end_stop;
    cnt_d      = (state_d != state_q) ? '0 : cnt_step;
    at_limit_d = (pos_d == '0) || (pos_d == PosMax);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      pos_q      <= PosInit;
      cnt_q      <= '0;
      dir_q      <= DirNone;
      timeout_q  <= 1'b0;
      at_limit_q <= (PosInit == '0) || (PosInit == PosMax);
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      timeout_q  <= timeout_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign DIR_0    = dir_q[0];
  assign DIR_1    = dir_q[1];
  assign POS      = pos_q;
  assign AT_LIMIT = at_limit_q;
  assign TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_sun_tracker_fsm.sv
// Scoreboard bench for sun_tracker_fsm: two instances (POS_INIT 90 and 178) with a fast tick.
module tb_sun_tracker_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, sv_a, d0_a, d1_a, lim_a, to_a;
  logic [11:0] a_a, b_a;
  logic [7:0]  pos_a;
  logic        rst_b, sv_b, d0_b, d1_b, lim_b, to_b;
  logic [11:0] a_b, b_b;
  logic [7:0]  pos_b;

  sun_tracker_fsm #(
    .DATA_W(12), .THRESH(64), .HYST(16), .TICK_DIV(4), .POS_MAX(180), .POS_INIT(90),
    .MOVE_MAX(8), .HOLD_TICKS(3)
  ) u_dut_a (
    .CLK(clk), .RST(rst_a), .SAMPLE_VALID(sv_a), .LDR_A(a_a), .LDR_B(b_a),
    .DIR_0(d0_a), .DIR_1(d1_a), .POS(pos_a), .AT_LIMIT(lim_a), .TIMEOUT(to_a)
  );

  sun_tracker_fsm #(
    .DATA_W(12), .THRESH(64), .HYST(16), .TICK_DIV(4), .POS_MAX(180), .POS_INIT(178),
    .MOVE_MAX(8), .HOLD_TICKS(3)
  ) u_dut_b (
    .CLK(clk), .RST(rst_b), .SAMPLE_VALID(sv_b), .LDR_A(a_b), .LDR_B(b_b),
    .DIR_0(d0_b), .DIR_1(d1_b), .POS(pos_b), .AT_LIMIT(lim_b), .TIMEOUT(to_b)
  );

  int total = 0;
  int bad = 0;
  int to_cnt_a = 0;
  int to_cnt_b = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb_q[$];

  task automatic check_val(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int act);
    exp_t e;
    check_val("sb_nonempty", int'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, act, e.val);
    end
  endtask

  function automatic bit dir_of(input bit on_b, input bit which);
    if (on_b) return which ? d1_b : d0_b;
    return which ? d1_a : d0_a;
  endfunction

  // One-cycle strobe; expected DIR pair is checked in the cycle after the sample edge.
  task automatic strobe(input bit on_b, input int a, input int b, input int e0, input int e1);
    sb_push(on_b ? "dir0_b" : "dir0_a", e0);
    sb_push(on_b ? "dir1_b" : "dir1_a", e1);
    @(posedge clk);
    #1;
    if (on_b) begin sv_b = 1'b1; a_b = 12'(a); b_b = 12'(b); end
    else      begin sv_a = 1'b1; a_a = 12'(a); b_a = 12'(b); end
    @(posedge clk);
    #1;
    sv_a = 1'b0;
    sv_b = 1'b0;
    @(negedge clk);
    sb_pop(int'(dir_of(on_b, 1'b0)));
    sb_pop(int'(dir_of(on_b, 1'b1)));
  endtask

  task automatic wait_level(input bit on_b, input bit which, input bit level, input int bound,
                            output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dir_of(on_b, which) != level && n <= bound);
  endtask

  always @(negedge clk) begin
    check_val("excl_a", int'(d0_a & d1_a), 0);
    check_val("excl_b", int'(d0_b & d1_b), 0);
    if (to_a) to_cnt_a++;
    if (to_b) to_cnt_b++;
  end

  initial begin
    int n, hi, p_stop, to_snap;
    rst_a = 1'b1; rst_b = 1'b1;
    sv_a = 1'b0; a_a = '0; b_a = '0;
    sv_b = 1'b0; a_b = '0; b_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sb_push("rst_dir0", 0); sb_push("rst_dir1", 0); sb_push("rst_pos", 90);
    sb_push("rst_lim", 0);  sb_push("rst_to", 0);   sb_push("rst_pos_b", 178);
    sb_push("rst_lim_b", 0);
    sb_pop(d0_a); sb_pop(d1_a); sb_pop(pos_a); sb_pop(lim_a); sb_pop(to_a);
    sb_pop(pos_b); sb_pop(lim_b);
    rst_a = 1'b0; rst_b = 1'b0;

    // Basic move, first tick, keep-moving inside hysteresis band, stop on balance.
    strobe(0, 2000, 1900, 1, 0);
    n = 0;
    while (pos_a == 8'd90 && n < 8) begin @(negedge clk); n++; end
    sb_push("first_tick_pos", 91);
    sb_pop(pos_a);
    strobe(0, 1040, 1000, 1, 0);
    strobe(0, 1000, 1000, 0, 0);
    p_stop = pos_a;

    // Held-high strobe through HOLD: ignored until 3 ticks elapse, then a fresh move.
    sv_a = 1'b1; a_a = 12'd2000; b_a = 12'd1000;
    wait_level(0, 0, 1, 20, n);
    sv_a = 1'b0;
    check_val("hold_len", int'(n >= 10 && n <= 13), 1);
    sb_push("pos_hold_unchanged", p_stop);
    sb_pop(pos_a);

    // Reversal while moving: goes to HOLD, never to MOVE_1.
    strobe(0, 1000, 1500, 0, 0);
    hi = 0;
    repeat (16) begin @(negedge clk); if (d1_a || d0_a) hi++; end
    check_val("rev_no_move", hi, 0);
    strobe(0, 1040, 1000, 0, 0);
    strobe(0, 1000, 1040, 0, 0);
    strobe(0, 2000, 1900, 1, 0);
    strobe(0, 1010, 1000, 0, 0);
    check_val("no_timeout_yet", to_cnt_a, 0);
    repeat (16) @(negedge clk);

    // Timeout: constant +500 from a fresh reset.
    rst_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    to_snap = to_cnt_a;
    sv_a = 1'b1; a_a = 12'd1500; b_a = 12'd1000;
    wait_level(0, 0, 1, 5, n);
    check_val("to_rise_lat", n, 1);
    hi = 1;
    while (hi <= 40) begin
      @(negedge clk);
      if (!d0_a) break;
      hi++;
    end
    check_val("to_dir_len", int'(hi >= 29 && hi <= 32), 1);
    sb_push("to_pulse", 1); sb_push("to_pos", 98); sb_push("to_lim", 0);
    sb_pop(to_a); sb_pop(pos_a); sb_pop(lim_a);
    @(negedge clk);
    sb_push("to_pulse_end", 0);
    sb_pop(to_a);
    wait_level(0, 0, 1, 16, n);
    check_val("re_move", int'(n <= 16), 1);
    sv_a = 1'b0;
    strobe(0, 1000, 1000, 0, 0);
    check_val("to_pulse_count", to_cnt_a - to_snap, 1);

    // Upper end-stop on instance B.
    sv_b = 1'b1; a_b = 12'd1500; b_b = 12'd1000;
    wait_level(1, 0, 1, 3, n);
    check_val("b_rise_lat", n, 1);
    wait_level(1, 0, 0, 20, n);
    check_val("b_fall", int'(n <= 20), 1);
    sb_push("b_pos_limit", 180); sb_push("b_at_limit", 1);
    sb_pop(pos_b); sb_pop(lim_b);
    check_val("b_no_timeout", to_cnt_b, 0);
    hi = 0;
    repeat (24) begin @(negedge clk); if (d0_b) hi++; end
    sv_b = 1'b0;
    check_val("b_blocked_at_max", hi, 0);
    strobe(1, 1000, 1500, 0, 1);
    strobe(1, 1000, 1000, 0, 0);
    repeat (16) @(negedge clk);

    // Async reset mid-move drops DIR at once.
    strobe(0, 2000, 1000, 1, 0);
    #2;
    rst_a = 1'b1;
    #1;
    sb_push("rst_mid_dir0", 0); sb_push("rst_mid_pos", 90);
    sb_pop(d0_a); sb_pop(pos_a);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    sb_push("post_rst_dir0", 0);
    sb_pop(d0_a);

    check_val("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
